// File: rtl/zbt_master.sv
// zbt_master -- client-side master for a ZBT (zero-bus-turnaround) synchronous SRAM.
//
// Accepts read/write requests on a valid/ready handshake, issues them to the
// memory back-to-back, and returns read data in request order through a
// 4-entry response FIFO protected by a credit scheme.
//
// Timing, relative to the accept edge A:
//   addr/wr         driven in the cycle after edge A+1 (one capture stage, one output stage)
//   write           driven in the cycle after edge A+3 (two data stages behind addr)
//   read data       sampled at edge A+3 and pushed into the FIFO (A+4 with the option below)
//
// Optional feature (compile-time macro ZBT_MASTER_RDATA_REG_EN):
//   defined   -> memory read data is registered once before the FIFO; the
//                read latency grows by one cycle and the credit covers that stage.
//   undefined -> read data goes straight from the memory bus into the FIFO.
//
// Ports:
//   clock, reset (async, active-low)
//   req_valid/req_ready/req_wr/req_addr/req_wdata  request channel
//   resp_valid/resp_ready/resp_data                 in-order read responses
//   busy                                            pipeline or FIFO occupied
//   wr/addr/write/data                              ZBT memory bus
module zbt_master #(
    parameter int LOG_ADDR = 19,
    parameter int LOG_MEM  = 36
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [LOG_ADDR-1:0] req_addr,
    input  logic [LOG_MEM-1:0]  req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [LOG_MEM-1:0]  resp_data,
    output logic                busy,
    output logic                wr,
    output logic [LOG_ADDR-1:0] addr,
    output logic [LOG_MEM-1:0]  write,
    input  logic [LOG_MEM-1:0]  data
);

    localparam int STAGES = 3;

    // Request pipeline: stage 0 is the accept register, stage 1 runs in
    // parallel with addr/wr, stage 2 feeds the write bus and the read capture.
    logic                run_reg;
    logic [STAGES-1:0]   stg_valid_reg;
    logic [STAGES-1:0]   stg_wr_reg;
    logic [LOG_MEM-1:0]  stg_wdata_reg [STAGES];
    logic [LOG_ADDR-1:0] s0_addr_reg;
    logic [STAGES-1:0]   stg_rd;

    logic [LOG_MEM-1:0]  fifo_mem [4];
    logic [1:0]          wptr_reg;
    logic [1:0]          rptr_reg;
    logic [2:0]          count_reg;

    logic                accept;
    logic                push;
    logic                pop;
    logic [LOG_MEM-1:0]  push_data;
    logic [3:0]          reads_in_flight;
    logic [3:0]          outstanding;
    logic                pipe_busy;

    assign stg_rd    = stg_valid_reg & ~stg_wr_reg;
    assign accept    = req_valid & req_ready;
    assign pop       = resp_valid & resp_ready;
    assign pipe_busy = |stg_valid_reg;

`ifdef ZBT_MASTER_RDATA_REG_EN
    logic                rd3_reg;
    logic [LOG_MEM-1:0]  rdata_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd3_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            rd3_reg   <= stg_rd[STAGES-1];
            rdata_reg <= data;
        end
    end

    assign push            = rd3_reg;
    assign push_data       = rdata_reg;
    assign reads_in_flight = 4'($countones(stg_rd)) + 4'(rd3_reg);
    assign busy            = pipe_busy | rd3_reg | resp_valid;
`else
    assign push            = stg_rd[STAGES-1];
    assign push_data       = data;
    assign reads_in_flight = 4'($countones(stg_rd));
    assign busy            = pipe_busy | resp_valid;
`endif

    // Credit: every read in the pipeline already owns a FIFO slot. A pop on
    // this same edge frees its slot in time for a new accept, which is what
    // lets a continuously drained stream run without bubbles.
    assign outstanding = {1'b0, count_reg} + reads_in_flight;
    assign req_ready   = run_reg & ((outstanding - 4'(pop)) < 4'd4);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_reg       <= 1'b0;
            stg_valid_reg <= '0;
            stg_wr_reg    <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stg_wdata_reg[i] <= '0;
            end
            s0_addr_reg   <= '0;
            wr            <= 1'b0;
            addr          <= '0;
            write         <= '0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
        end else begin
            run_reg          <= 1'b1;
            stg_valid_reg    <= {stg_valid_reg[STAGES-2:0], accept};
            stg_wr_reg       <= {stg_wr_reg[STAGES-2:0], req_wr};
            stg_wdata_reg[0] <= req_wdata;
            for (int i = 1; i < STAGES; i++) begin
                stg_wdata_reg[i] <= stg_wdata_reg[i-1];
            end
            s0_addr_reg      <= req_addr;

            wr <= stg_valid_reg[0] & stg_wr_reg[0];
            // Address bus parks on the last issued address when idle.
            if (stg_valid_reg[0]) begin
                addr <= s0_addr_reg;
            end
            write <= (stg_valid_reg[STAGES-1] & stg_wr_reg[STAGES-1])
                     ? stg_wdata_reg[STAGES-1] : '0;

            if (push) begin
                wptr_reg <= wptr_reg + 2'd1;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wptr_reg] <= push_data;
        end
    end

    assign resp_valid = (count_reg != 3'd0);
    assign resp_data  = resp_valid ? fifo_mem[rptr_reg] : '0;

endmodule

// File: tb/tb_zbt_master.sv
// tb_zbt_master -- self-checking bench for zbt_master.
//
// Contains a behavioural ZBT memory that drives the data bus from the DUT's
// memory-side outputs, and a transaction-level model that predicts every DUT
// output from the accepted request list, an ideal shadow memory and a queue
// of expected responses. Directed sequences with literal expectations run
// first, followed by a randomized phase.
module tb_zbt_master;

    localparam int LA = 10;
    localparam int LM = 36;
`ifdef ZBT_MASTER_RDATA_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [LA-1:0] req_addr;
    logic [LM-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [LM-1:0] resp_data;
    logic          busy;
    logic          wr;
    logic [LA-1:0] addr;
    logic [LM-1:0] write;
    logic [LM-1:0] data;

    zbt_master #(.LOG_ADDR(LA), .LOG_MEM(LM)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .wr(wr), .addr(addr), .write(write), .data(data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // ---------------- behavioural memory ----------------
    logic [LM-1:0] mem    [1 << LA];
    logic [LM-1:0] shadow [1 << LA];
    logic          wr_d1 = 1'b0, wr_d2 = 1'b0;
    logic [LA-1:0] addr_d1 = '0, addr_d2 = '0;

    initial begin
        logic [63:0] g;
        data = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                wr_d1 = 1'b0;
                wr_d2 = 1'b0;
            end else begin
                // write data arrives two cycles after its address
                if (wr_d2) mem[addr_d2] = write;
                // read data for last cycle's address goes out now
                if (wr_d1) begin
                    g = {$urandom(), $urandom()};
                    data = g[LM-1:0];
                end else begin
                    data = mem[addr_d1];
                end
                wr_d2 = wr_d1;
                addr_d2 = addr_d1;
                wr_d1 = wr;
                addr_d1 = addr;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit            w;
        logic [LA-1:0] a;
        logic [LM-1:0] wd;
        logic [LM-1:0] rexp;
        int            t;
    } txn_t;

    txn_t          txq[$];
    logic [LM-1:0] expq[$];
    int            n = 0;
    bit            run = 1'b0;
    logic          exp_wr = 1'b0;
    logic [LA-1:0] exp_addr = '0;
    logic [LM-1:0] exp_write = '0;

    // Outstanding reads (in pipe + queued) may never exceed 4 after an edge.
    function automatic bit model_ready();
        int inflight = 0;
        int occ;
        int p;
        foreach (txq[i]) if (!txq[i].w && (n - txq[i].t) < LAT) inflight++;
        occ = expq.size();
        p = (occ > 0 && resp_ready) ? 1 : 0;
        return run && ((occ + inflight - p) < 4);
    endfunction

    function automatic bit model_busy();
        bit b = (expq.size() > 0);
        foreach (txq[i]) begin
            if ((n - txq[i].t) <= 2) b = 1'b1;
            if (LAT == 4 && !txq[i].w && (n - txq[i].t) == 3) b = 1'b1;
        end
        return b;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            txq.delete();
            expq.delete();
            n = 0;
            run = 1'b0;
            exp_wr = 1'b0;
            exp_addr = '0;
            exp_write = '0;
        end else begin
            bit acc;
            bit pp;
            txn_t nt;
            acc = req_valid && model_ready();
            pp = (expq.size() > 0) && resp_ready;
            n++;
            if (pp) void'(expq.pop_front());
            exp_wr = 1'b0;
            exp_write = '0;
            foreach (txq[i]) begin
                if (txq[i].t == n - 1) begin
                    exp_wr = txq[i].w;
                    exp_addr = txq[i].a;
                end
                if (txq[i].t == n - 3 && txq[i].w) exp_write = txq[i].wd;
                if (txq[i].t == n - LAT && !txq[i].w) expq.push_back(txq[i].rexp);
            end
            if (acc) begin
                nt.w = req_wr;
                nt.a = req_addr;
                nt.wd = req_wdata;
                nt.t = n;
                nt.rexp = '0;
                if (req_wr) shadow[req_addr] = req_wdata;
                else nt.rexp = shadow[req_addr];
                txq.push_back(nt);
            end
            while (txq.size() > 0 && (n - txq[0].t) > 5) void'(txq.pop_front());
            run = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_wr", wr, 0);
            chk("rst_addr", addr, 0);
            chk("rst_write", write, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
        end else begin
            chk("req_ready", req_ready, model_ready());
            chk("wr", wr, exp_wr);
            chk("addr", addr, exp_addr);
            chk("write", write, exp_write);
            chk("resp_valid", resp_valid, expq.size() > 0);
            if (expq.size() > 0) chk("resp_data", resp_data, expq[0]);
            chk("busy", busy, model_busy());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request until accepted; caller is #1 after a rising edge.
    task automatic issue(input bit w, input int a, input logic [LM-1:0] d);
        int guard = 0;
        bit ok;
        req_valid = 1'b1;
        req_wr = w;
        req_addr = LA'(a);
        req_wdata = d;
        do begin
            @(negedge clock);
            ok = req_ready;
            @(posedge clock);
            #1;
            guard++;
        end while (!ok && guard < 200);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got no accept, expected accept within 200 cycles");
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r64;
        int k;
        int g;
        bit r;

        for (int i = 0; i < (1 << LA); i++) begin
            mem[i] = LM'(i * 7 + 3);
            shadow[i] = LM'(i * 7 + 3);
        end
        req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; resp_ready = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        chk("ready_before_first_edge", req_ready, 0);
        tick();
        @(negedge clock);
        chk("ready_after_reset", req_ready, 1);
        tick();

        // single read of address 5
        req_valid = 1; req_wr = 0; req_addr = 5;
        tick();                       // edge A
        req_valid = 0;
        @(negedge clock);             // after A
        @(negedge clock);             // after A+1
        chk("rd5_addr", addr, 5);
        chk("rd5_wr", wr, 0);
        @(negedge clock);             // after A+2
        chk("rd5_valid_early", resp_valid, 0);
        @(negedge clock);             // after A+3
`ifdef ZBT_MASTER_RDATA_REG_EN
        chk("rd5_valid_a3", resp_valid, 0);
        @(negedge clock);
`endif
        chk("rd5_valid", resp_valid, 1);
        chk("rd5_data", resp_data, 38);
        tick();
        resp_ready = 1;
        repeat (4) tick();

        // write 7 = 0x123 then read 7 on the next accept
        issue(1, 7, 36'h123);         // accepted at A
        issue(0, 7, 0);               // accepted at A+1
        @(negedge clock);             // after A+1
        @(negedge clock);             // after A+2
        chk("wr7_write_early", write, 0);
        @(negedge clock);             // after A+3
        chk("wr7_write", write, 36'h123);
        g = 0;
        while (!resp_valid && g < 8) begin
            @(negedge clock);
            g++;
        end
        chk("raw7_valid", resp_valid, 1);
        chk("raw7_data", resp_data, 36'h123);
        tick();
        repeat (6) tick();

        // 30 writes then 30 reads, drained continuously
        for (int i = 0; i < 30; i++) issue(1, i, LM'(1000 - i));
        fork
            begin
                for (int i = 0; i < 30; i++) issue(0, i, '0);
            end
            begin
                int w = 0;
                do begin
                    @(negedge clock);
                    w++;
                end while (!resp_valid && w < 60);
                for (int i = 0; i < 30; i++) begin
                    chk("seq_valid", resp_valid, 1);
                    chk("seq_data", resp_data, 64'(1000 - i));
                    if (i < 29) @(negedge clock);
                end
            end
        join
        tick();
        repeat (6) tick();

        // credit limit with a stalled consumer
        resp_ready = 0;
        k = 0;
        req_valid = 1; req_wr = 0; req_addr = 40;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            r = req_ready;
            tick();
            if (r) begin
                k++;
                req_addr = LA'(40 + k);
            end
        end
        chk("credit_accepts", k, 4);
        @(negedge clock);
        chk("credit_ready_low", req_ready, 0);
        tick();
        resp_ready = 1;
        for (int c = 0; c < 30 && k < 6; c++) begin
            @(negedge clock);
            r = req_ready;
            tick();
            if (r) begin
                k++;
                req_addr = LA'(40 + k);
                if (k == 6) req_valid = 0;
            end
        end
        req_valid = 0;
        chk("credit_rest", k, 6);
        repeat (10) tick();

        // full FIFO, then continuous reads across pointer wrap
        resp_ready = 0;
        for (int i = 0; i < 4; i++) issue(0, 60 + i, '0);
        repeat (4) tick();
        @(negedge clock);
        chk("full_head", resp_data, 423);
        chk("full_busy", busy, 1);
        tick();
        resp_ready = 1;
        for (int i = 0; i < 8; i++) issue(0, 64 + i, '0);
        repeat (10) tick();

        // reset with three reads in flight
        resp_ready = 0;
        for (int i = 0; i < 3; i++) issue(0, 1 + i, '0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_wr", wr, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_write", write, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        resp_ready = 1;
        repeat (8) begin
            @(negedge clock);
            chk("post_rst_no_resp", resp_valid, 0);
        end
        tick();

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            req_valid = ($urandom_range(0, 9) < 6);
            req_wr = ($urandom_range(0, 9) < 4);
            req_addr = LA'($urandom_range(0, 15));
            r64 = {$urandom(), $urandom()};
            req_wdata = r64[LM-1:0];
            resp_ready = ((c / 50) % 3 == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
            tick();
        end
        req_valid = 0;
        resp_ready = 1;
        repeat (12) tick();
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_ready", req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zbt_master.md
ZBT_MASTER -- requirements
Module: zbt_master

Interface
REQ-001 Parameter LOG_ADDR, default 19, ZBT word-address width.
REQ-002 Parameter LOG_MEM, default 36, ZBT data word width.
REQ-003 clock  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; block held in reset while low.
REQ-005 req_valid  input  1  client request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_wr  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  LOG_ADDR  request word address.
REQ-009 req_wdata  input  LOG_MEM  write data.
REQ-010 resp_valid  output  1  read data available at resp_data.
REQ-011 resp_ready  input  1  client consumes the response this cycle.
REQ-012 resp_data  output  LOG_MEM  read data, in request order.
REQ-013 busy  output  1  a transaction is in the memory pipeline or the response FIFO.
REQ-014 wr  output  1  memory write strobe, to the memory model.
REQ-015 addr  output  LOG_ADDR  memory address.
REQ-016 write  output  LOG_MEM  memory write data.
REQ-017 data  input  LOG_MEM  memory read data.

Function
REQ-018 A request is accepted on a rising edge where req_valid and req_ready are both 1; otherwise req_* is ignored.
REQ-019 Cycle A+1 after acceptance edge A: addr = req_addr and wr = req_wr, both registered; with no accept, wr = 0 and addr holds its last value.
REQ-020 Writes: write = req_wdata during cycle A+3 (two-stage data pipeline behind addr); write = 0 in every other cycle.
REQ-021 Reads: data sampled at edge A+3 and pushed into a 4-entry response FIFO; resp_valid high from cycle A+3.
REQ-022 Accepts on consecutive cycles are issued back-to-back with no bubbles, including read/write mixes.
REQ-023 resp_valid = FIFO not empty; resp_data = FIFO head; pop on edge with resp_valid and resp_ready.
REQ-024 Same-edge push and pop: occupancy unchanged, order preserved.
REQ-025 Credit: req_ready = 1 iff (FIFO occupancy + reads in flight) < 4; applies to reads and writes alike.
REQ-026 The FIFO never overflows; a pop of an empty FIFO is impossible by construction (resp_valid = 0).
REQ-027 Read/write pointers wrap modulo 4; occupancy counter is 3 bits, range 0..4.
REQ-028 busy = 1 while any read or write is in the 3-stage pipeline or the FIFO is non-empty.
REQ-029 Write-then-read to the same address on consecutive accepts returns the new data; the block adds no reordering.

Reset
REQ-030 While reset is low: wr = 0, addr = 0, write = 0, resp_valid = 0, resp_data = 0, busy = 0, req_ready = 0.
REQ-031 Reset assertion mid-operation discards all in-flight transactions and FIFO contents immediately, with no further memory strobes.
REQ-032 req_ready = 1 from the first rising edge after reset deasserts.

Configuration
REQ-033 Macro ZBT_MASTER_RDATA_REG_EN defined: data registered once before the FIFO; read latency A+4; credit counts the extra stage.
REQ-034 Macro undefined: read latency A+3 per REQ-021; write timing unchanged either way.

Verification
REQ-035 Write 30 words, addr i, data 1000-i, back-to-back, then read addr 0..29 with resp_ready=1 -> resp_data sequence 1000..971, no gaps after the first.
REQ-036 Single read of addr 5 accepted at edge 0 -> wr=0, addr=5 in cycle 1; resp_valid rises cycle 3 (cycle 4 with macro).
REQ-037 resp_ready=0, req_valid=1 for 6 reads -> exactly 4 accepted, req_ready low; resp_ready=1 -> 4 responses in order, then remaining 2 accepted.
REQ-038 Write addr 7 = 0x123 then read addr 7 on the next cycle -> write=0x123 in cycle 3, resp_data=0x123.
REQ-039 Reset low with 3 reads in flight -> all outputs go to reset values immediately; no resp_valid after reset is released.
REQ-040 FIFO full, same-edge pop and new read data arrival -> occupancy stays 4, order correct across pointer wrap.
